// File: rtl/game_state_ctl.sv
// Arkanoid game sequencer: serve/play/lost/win/over flow, lives and score tracking.
// Every output is registered in the pclk domain.
module game_state_ctl #(
    parameter int LIVES_INIT  = 3,
    parameter int FLOOR_Y     = 760,
    parameter int LOST_FRAMES = 60,
    parameter int END_FRAMES  = 120
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        mouse_left,
    input  logic        vsync_in,
    input  logic [11:0] ball_y,
    input  logic [15:0] blocks_in,
    output logic        ball_run,
    output logic        ball_reset,
    output logic        blocks_restore,
    output logic [1:0]  lives,
    output logic [11:0] score,
    output logic [2:0]  game_state
);

    localparam logic [1:0]  LIVES_RST = 2'(LIVES_INIT);
    localparam logic [11:0] FLOOR_LIM = 12'(FLOOR_Y);
    localparam logic [7:0]  LOST_CNT  = 8'(LOST_FRAMES);
    localparam logic [7:0]  END_CNT   = 8'(END_FRAMES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_LOST  = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } state_t;

    state_t      state, state_next;
    logic        mouse_sync1, mouse_sync2, mouse_prev, click;
    logic        vsync_d, vsync_d2, frame_tick;
    logic [7:0]  frame_cnt, frame_cnt_next;
    logic [15:0] blocks_prev, cleared;
    logic [4:0]  cleared_cnt;
    logic [12:0] score_sum;
    logic [11:0] score_sat, score_next;
    logic [1:0]  lives_next;
    logic        ball_reset_next, blocks_restore_next;

    // Button is asynchronous: two flops before edge detection, click is registered.
    always_ff @(posedge pclk) begin
        if (reset) begin
            mouse_sync1 <= 1'b0;
            mouse_sync2 <= 1'b0;
            mouse_prev  <= 1'b0;
            click       <= 1'b0;
            vsync_d     <= 1'b0;
            vsync_d2    <= 1'b0;
        end else begin
            mouse_sync1 <= mouse_left;
            mouse_sync2 <= mouse_sync1;
            mouse_prev  <= mouse_sync2;
            click       <= mouse_sync2 & ~mouse_prev;
            vsync_d     <= vsync_in;
            vsync_d2    <= vsync_d;
        end
    end

    assign frame_tick = vsync_d & ~vsync_d2;

    // Only 1->0 brick transitions score; restores never do.
    assign cleared = blocks_prev & ~blocks_in;

    always_comb begin
        cleared_cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cleared_cnt = cleared_cnt + {4'd0, cleared[i]};
        end
    end

    assign score_sum = {1'b0, score} + {8'd0, cleared_cnt};
    assign score_sat = score_sum[12] ? 12'hFFF : score_sum[11:0];

    always_comb begin
        state_next          = state;
        lives_next          = lives;
        score_next          = score;
        ball_reset_next     = 1'b0;
        blocks_restore_next = 1'b0;
        frame_cnt_next      = frame_cnt;
        case (state)
            ST_IDLE: begin
                if (click) begin
                    state_next          = ST_SERVE;
                    ball_reset_next     = 1'b1;
                    blocks_restore_next = 1'b1;
                    lives_next          = LIVES_RST;
                    score_next          = 12'd0;
                end
            end
            ST_SERVE: begin
                if (click) state_next = ST_PLAY;
            end
            ST_PLAY: begin
                score_next = score_sat;
                if (blocks_in == 16'd0) begin
                    state_next = ST_WIN;
                end else if (ball_y >= FLOOR_LIM) begin
                    state_next = ST_LOST;
                    if (lives != 2'd0) lives_next = lives - 2'd1;
                end
            end
            ST_LOST: begin
                if (frame_tick) frame_cnt_next = frame_cnt + 8'd1;
                if (frame_cnt == LOST_CNT) begin
                    if (lives == 2'd0) begin
                        state_next = ST_OVER;
                    end else begin
                        state_next      = ST_SERVE;
                        ball_reset_next = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (frame_tick) frame_cnt_next = frame_cnt + 8'd1;
                if (frame_cnt == END_CNT) state_next = ST_IDLE;
            end
            ST_WIN: begin
                if (frame_tick) frame_cnt_next = frame_cnt + 8'd1;
                if (frame_cnt == END_CNT) begin
                    state_next          = ST_SERVE;
                    ball_reset_next     = 1'b1;
                    blocks_restore_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (state_next != state) frame_cnt_next = 8'd0;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state          <= ST_IDLE;
            lives          <= LIVES_RST;
            score          <= 12'd0;
            frame_cnt      <= 8'd0;
            blocks_prev    <= 16'd0;
            ball_run       <= 1'b0;
            ball_reset     <= 1'b0;
            blocks_restore <= 1'b0;
        end else begin
            state          <= state_next;
            lives          <= lives_next;
            score          <= score_next;
            frame_cnt      <= frame_cnt_next;
            blocks_prev    <= blocks_in;
            ball_run       <= (state_next == ST_PLAY);
            ball_reset     <= ball_reset_next;
            blocks_restore <= blocks_restore_next;
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_game_state_ctl.sv
// Scoreboard bench for game_state_ctl: directed game flow, expected events queued
// by the driver and popped by a monitor on state changes, pulses and score changes.
module tb_game_state_ctl;

    logic        pclk;
    logic        reset;
    logic        mouse_left;
    logic        vsync_in;
    logic [11:0] ball_y;
    logic [15:0] blocks_in;
    logic        ball_run;
    logic        ball_reset;
    logic        blocks_restore;
    logic [1:0]  lives;
    logic [11:0] score;
    logic [2:0]  game_state;

    int checks   = 0;
    int failures = 0;
    int exp_score = 0;
    bit mon_en = 0;

    // {state, lives, ball_run}
    logic [5:0]  exp_state_q[$];
    // {blocks_restore, ball_reset, state}
    logic [4:0]  exp_pulse_q[$];
    logic [11:0] exp_score_q[$];

    game_state_ctl dut (
        .pclk           (pclk),
        .reset          (reset),
        .mouse_left     (mouse_left),
        .vsync_in       (vsync_in),
        .ball_y         (ball_y),
        .blocks_in      (blocks_in),
        .ball_run       (ball_run),
        .ball_reset     (ball_reset),
        .blocks_restore (blocks_restore),
        .lives          (lives),
        .score          (score),
        .game_state     (game_state)
    );

    // clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic press(input int hold);
        mouse_left = 1'b1;
        wait_cycles(hold);
        mouse_left = 1'b0;
        wait_cycles(6);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vsync_in = 1'b1;
            wait_cycles(2);
            vsync_in = 1'b0;
            wait_cycles(2);
        end
    endtask

    task automatic push_state(input logic [2:0] s, input logic [1:0] l, input logic r);
        exp_state_q.push_back({s, l, r});
    endtask

    task automatic push_pulse(input logic restore, input logic rst_ball, input logic [2:0] s);
        exp_pulse_q.push_back({restore, rst_ball, s});
    endtask

    // Drive a new brick bitmap while in PLAY and queue the resulting score.
    task automatic play_blocks(input logic [15:0] v);
        int n;
        int nxt;
        n = $countones(blocks_in & ~v);
        nxt = exp_score + n;
        if (nxt > 4095) nxt = 4095;
        if (nxt != exp_score) exp_score_q.push_back(12'(nxt));
        exp_score = nxt;
        blocks_in = v;
        wait_cycles(1);
    endtask

    // monitor / scoreboard
    logic [2:0]  prev_state = 3'd0;
    logic [11:0] prev_score = 12'd0;

    always @(negedge pclk) begin
        if (mon_en) begin
            if (game_state != prev_state) begin
                if (exp_state_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL state_event actual=%0d required=none", game_state);
                end else begin
                    check("state_event", {26'd0, game_state, lives, ball_run}, {26'd0, exp_state_q.pop_front()});
                end
            end
            if (ball_reset || blocks_restore) begin
                if (exp_pulse_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL pulse_event actual=%0b%0b required=none", blocks_restore, ball_reset);
                end else begin
                    check("pulse_event", {27'd0, blocks_restore, ball_reset, game_state}, {27'd0, exp_pulse_q.pop_front()});
                end
            end
            if (score != prev_score) begin
                if (exp_score_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL score_event actual=%0d required=none", score);
                end else begin
                    check("score_event", {20'd0, score}, {20'd0, exp_score_q.pop_front()});
                end
            end
        end
        prev_state = game_state;
        prev_score = score;
    end

    // stimulus
    initial begin
        reset      = 1'b1;
        mouse_left = 1'b0;
        vsync_in   = 1'b0;
        ball_y     = 12'd100;
        blocks_in  = 16'hFFFF;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(1);
        check("rst_state", {29'd0, game_state}, 32'd0);
        check("rst_lives", {30'd0, lives}, 32'd3);
        check("rst_score", {20'd0, score}, 32'd0);
        check("rst_outs", {29'd0, ball_run, ball_reset, blocks_restore}, 32'd0);
        mon_en = 1'b1;

        // Start: pulses land 4 cycles after the button edge, once for a held button.
        push_state(3'd1, 2'd3, 1'b0);
        push_pulse(1'b1, 1'b1, 3'd1);
        mouse_left = 1'b1;
        wait_cycles(3);
        check("start_pre_pulse", {30'd0, blocks_restore, ball_reset}, 32'd0);
        wait_cycles(1);
        check("start_pulse", {30'd0, blocks_restore, ball_reset}, 32'd3);
        check("start_state", {29'd0, game_state}, 32'd1);
        wait_cycles(1);
        check("start_pulse_end", {30'd0, blocks_restore, ball_reset}, 32'd0);
        wait_cycles(8);
        mouse_left = 1'b0;
        wait_cycles(6);

        push_state(3'd2, 2'd3, 1'b1);
        press(10);
        check("serve_run", {31'd0, ball_run}, 32'd1);

        // Three bricks cleared in one cycle, then restored.
        play_blocks(16'hFDDE);
        check("score_3", {20'd0, score}, 32'd3);
        play_blocks(16'hFFFF);
        wait_cycles(1);
        check("score_keep", {20'd0, score}, 32'd3);

        // First loss, re-serve after exactly 60 frames.
        push_state(3'd3, 2'd2, 1'b0);
        ball_y = 12'd760;
        wait_cycles(2);
        ball_y = 12'd100;
        check("lost_run", {31'd0, ball_run}, 32'd0);
        frames(59);
        check("lost_59", {29'd0, game_state}, 32'd3);
        push_state(3'd1, 2'd2, 1'b0);
        push_pulse(1'b0, 1'b1, 3'd1);
        frames(1);
        check("lost_60", {29'd0, game_state}, 32'd1);

        // Second and third losses lead to OVER.
        push_state(3'd2, 2'd2, 1'b1);
        press(10);
        push_state(3'd3, 2'd1, 1'b0);
        ball_y = 12'd900;
        wait_cycles(2);
        ball_y = 12'd100;
        push_state(3'd1, 2'd1, 1'b0);
        push_pulse(1'b0, 1'b1, 3'd1);
        frames(60);
        push_state(3'd2, 2'd1, 1'b1);
        press(10);
        push_state(3'd3, 2'd0, 1'b0);
        ball_y = 12'd760;
        wait_cycles(2);
        ball_y = 12'd100;
        push_state(3'd4, 2'd0, 1'b0);
        frames(60);
        check("over_state", {29'd0, game_state}, 32'd4);
        frames(10);
        press(5);
        frames(109);
        check("over_119", {29'd0, game_state}, 32'd4);
        push_state(3'd0, 2'd0, 1'b0);
        frames(1);
        check("over_idle", {29'd0, game_state}, 32'd0);

        // New game clears score and reloads lives.
        push_state(3'd1, 2'd3, 1'b0);
        push_pulse(1'b1, 1'b1, 3'd1);
        exp_score_q.push_back(12'd0);
        exp_score = 0;
        press(10);
        push_state(3'd2, 2'd3, 1'b1);
        press(10);

        // Empty field and floor hit together: WIN, lives kept, last 16 bricks scored.
        push_state(3'd5, 2'd3, 1'b0);
        ball_y = 12'd800;
        play_blocks(16'h0000);
        ball_y = 12'd100;
        frames(119);
        check("win_119", {29'd0, game_state}, 32'd5);
        check("win_lives", {30'd0, lives}, 32'd3);
        push_state(3'd1, 2'd3, 1'b0);
        push_pulse(1'b1, 1'b1, 3'd1);
        frames(1);
        check("win_serve", {29'd0, game_state}, 32'd1);
        blocks_in = 16'hFFFF;
        wait_cycles(2);
        check("win_score", {20'd0, score}, 32'd16);

        // Saturation: 16 + 271*15 + 13 = 4094, then 4 more clamps at 4095.
        push_state(3'd2, 2'd3, 1'b1);
        press(10);
        for (int i = 0; i < 271; i++) begin
            play_blocks(16'h8000);
            play_blocks(16'hFFFF);
        end
        play_blocks(16'hE000);
        check("score_4094", {20'd0, score}, 32'd4094);
        play_blocks(16'hFFFF);
        play_blocks(16'hFFF0);
        check("score_sat", {20'd0, score}, 32'd4095);
        play_blocks(16'hFFFF);
        play_blocks(16'hFF0F);
        wait_cycles(1);
        check("score_hold", {20'd0, score}, 32'd4095);

        // Reset in the middle of LOST.
        push_state(3'd3, 2'd2, 1'b0);
        ball_y = 12'd760;
        wait_cycles(2);
        ball_y = 12'd100;
        frames(30);
        push_state(3'd0, 2'd3, 1'b0);
        exp_score_q.push_back(12'd0);
        reset = 1'b1;
        wait_cycles(1);
        check("mid_rst_state", {29'd0, game_state}, 32'd0);
        check("mid_rst_lives", {30'd0, lives}, 32'd3);
        check("mid_rst_score", {20'd0, score}, 32'd0);
        check("mid_rst_outs", {29'd0, ball_run, ball_reset, blocks_restore}, 32'd0);
        reset = 1'b0;
        wait_cycles(5);

        // final report
        check("state_q_empty", exp_state_q.size(), 32'd0);
        check("pulse_q_empty", exp_pulse_q.size(), 32'd0);
        check("score_q_empty", exp_score_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_state_ctl.md
Name: game_state_ctl

Overview:
- Top-level game sequencer for Arkanoid.
- Runs in the pclk domain next to the ball, collision and board blocks.
- Decides when the ball moves, when it is re-served, and when the brick field is restored.
- Tracks lives and score; exposes the state code for on-screen text and LED debug.
- Uses the mouse left button as the start/serve input, the frame vsync as the time base, the ball Y position for loss detection, and the brick bitmap for win detection and scoring.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..3).
- FLOOR_Y, 760, ball_y at or above this value means the ball is lost.
- LOST_FRAMES, 60, frames spent in LOST before re-serve or game over (1..255).
- END_FRAMES, 120, frames spent in WIN or OVER before moving on (1..255).

Ports:
- pclk  in  1  pixel clock (65 MHz), sole clock.
- reset  in  1  synchronous, active-high reset.
- mouse_left  in  1  raw left button, asynchronous to pclk.
- vsync_in  in  1  frame vsync from the timing generator.
- ball_y  in  12  current ball Y position.
- blocks_in  in  16  brick-alive bitmap (1 = brick present).
- ball_run  out  1  ball motion enable.
- ball_reset  out  1  one-cycle pulse: place ball on the paddle.
- blocks_restore  out  1  one-cycle pulse: refill all bricks.
- lives  out  2  remaining lives.
- score  out  12  bricks destroyed, saturating.
- game_state  out  3  state code.

Behaviour:
- Clock and reset: one clock (pclk); reset is synchronous and active-high. Reset has priority over everything, including mid-operation.
- Reset values: state=IDLE, ball_run=0, ball_reset=0, blocks_restore=0, lives=LIVES_INIT, score=0, frame counter=0, synchronizers=0.
- click: mouse_left passes through a 2-FF synchronizer, then rising-edge detect. click is a one-cycle pulse, 3 cycles after the input edge. A held button gives exactly one click.
- frame_tick: one-cycle pulse on a registered rising edge of vsync_in.
- State codes: IDLE=0, SERVE=1, PLAY=2, LOST=3, OVER=4, WIN=5.
- Outputs are registered. ball_run=1 exactly while state==PLAY. game_state reflects the current state.
- IDLE:
  - On click: go to SERVE, pulse blocks_restore and ball_reset (1 cycle, the cycle after the click), lives<=LIVES_INIT, score<=0.
- SERVE:
  - On click: go to PLAY.
- PLAY (checked every cycle, in priority order):
  - 1) blocks_in==0: go to WIN.
  - 2) ball_y>=FLOOR_Y (unsigned compare): go to LOST, lives<=lives-1.
  - Clicks are ignored.
  - A simultaneous empty field and floor hit resolves as WIN; lives are not decremented.
- LOST:
  - Frame counter clears on entry and increments on each frame_tick.
  - When the count reaches LOST_FRAMES:
    - lives==0: go to OVER.
    - Otherwise: go to SERVE with a ball_reset pulse.
- OVER:
  - After END_FRAMES ticks: go to IDLE.
  - Clicks are ignored throughout OVER.
- WIN:
  - After END_FRAMES ticks: go to SERVE, pulse blocks_restore and ball_reset.
  - lives and score are kept.
- Frame counter: 8-bit; clears on every state change.
- Scoring:
  - blocks_prev is registered from blocks_in every cycle, in all states.
  - In PLAY only: score<=score+popcount(blocks_prev & ~blocks_in). This gives one cycle of latency and correctly counts several bricks cleared in the same cycle.
  - Score saturates at 4095 and never wraps.
  - 0->1 transitions (restore) never change the score. No score changes occur outside PLAY.
- lives never underflows: decrement happens only on PLAY->LOST, and re-serve requires lives>0.
- Pulses never overlap between consecutive cycles. One transition produces one pulse cycle.

Test Plan:
- Reset, then a mouse_left rising edge: state 0->1; blocks_restore and ball_reset high 1 cycle, 4 cycles after the edge; lives=3, score=0, ball_run=0.
- SERVE + click: state=2, ball_run=1. Clear bits 0, 5, 9 of blocks_in in the same cycle: score=3 one cycle later. Set them again: score stays 3.
- PLAY, drive ball_y=760 with LIVES_INIT=3: state=3, lives=2, ball_run=0. After exactly 60 vsync rising edges: state=1 with one ball_reset pulse.
- Lose three times: third LOST goes to OVER (4) after 60 frames. OVER goes to IDLE after 120 frames; clicks during OVER have no effect.
- PLAY, blocks_in becomes 0 in the same cycle ball_y=800: state=5, lives unchanged. After 120 frames: SERVE with blocks_restore + ball_reset pulses; score retained.
- Preload score near saturation (4094), clear 4 bricks at once: score=4095. Assert reset during LOST at frame 30: next cycle all outputs at reset values, state=0.
